// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding, mode-0
// bus polarity/phase, and a ceiling-log2 helper for counter sizing.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCK_HI,
      SCK_LO,
      HOLD,
      TEARDOWN,
      GAP
   } spi_state_t;

   localparam logic SPI_MODE0_CPOL = 1'b0;
   localparam logic SPI_MODE0_CPHA = 1'b0;

   // Half-period timer width; CLK_DIV tops out at 255.
   localparam int unsigned DIV_W = 8;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned bits;
      int unsigned span;
      bits = 0;
      span = 1;
      while (span < value) begin
         span = span << 1;
         bits++;
      end
      return bits;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable half-period down-counter; tick is high while the count sits at zero.
module spi_clk_div #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tick
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI bus master with byte start/ready handshake and optional ss hold
// between consecutive frames.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   input  logic [DATA_W-1:0] tx_byte,
   input  logic              miso,
   output logic              ready,
   output logic              busy,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_byte,
   output logic              sclk,
   output logic              ss,
   output logic              mosi
);

   localparam int unsigned      BIT_W     = clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] RELOAD    = DIV_W'(CLK_DIV - 1);
   // The frame-end cycle already counts as the first low-ss cycle of teardown.
   localparam logic [DIV_W-1:0] RELOAD_TD = DIV_W'(CLK_DIV - 2);

   spi_state_t state;
   spi_state_t state_next;

   logic              tick;
   logic              div_load;
   logic [DIV_W-1:0]  div_val;
   logic [DATA_W-1:0] shift_tx;
   logic [DATA_W-1:0] shift_rx;
   logic [BIT_W-1:0]  bit_cnt;
   logic              accept;
   logic              rise;
   logic              fall;
   logic              sample_edge;
   logic              frame_end;

   spi_clk_div #(
      .W (DIV_W)
   ) u_clk_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .load_val (div_val),
      .tick     (tick)
   );

   assign accept      = start && ready;
   assign frame_end   = (state == SCK_LO) && (bit_cnt == '0);
   assign rise        = tick && ((state == SETUP) || ((state == SCK_LO) && (bit_cnt != '0)));
   assign fall        = tick && (state == SCK_HI);
   assign sample_edge = SPI_MODE0_CPHA ? fall : rise;

   assign div_load = (state_next != state);
   assign div_val  = (state_next == TEARDOWN) ? RELOAD_TD : RELOAD;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:     if (start) state_next = SETUP;
         SETUP:    if (tick) state_next = SCK_HI;
         SCK_HI:   if (tick) state_next = SCK_LO;
         SCK_LO: begin
            if (frame_end) begin
               state_next = hold ? HOLD : TEARDOWN;
            end else if (tick) begin
               state_next = SCK_HI;
            end
         end
         HOLD:     if (start) state_next = SETUP;
         TEARDOWN: if (tick) state_next = GAP;
         GAP:      if (tick) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE) || (state == HOLD);
      busy  = ~ready;
      sclk  = (state == SCK_HI) ^ SPI_MODE0_CPOL;
      ss    = (state == IDLE) || (state == GAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_tx <= '0;
         shift_rx <= '0;
         bit_cnt  <= '0;
         mosi     <= 1'b0;
         rx_valid <= 1'b0;
         rx_byte  <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (accept) begin
            shift_tx <= tx_byte;
            mosi     <= tx_byte[DATA_W-1];
            bit_cnt  <= BIT_W'(DATA_W);
         end
         if (sample_edge) begin
            shift_rx <= {shift_rx[DATA_W-2:0], miso};
         end
         // The last falling edge closes the frame; mosi keeps its final bit.
         if (fall) begin
            bit_cnt <= bit_cnt - BIT_W'(1);
            if (bit_cnt == BIT_W'(1)) begin
               rx_valid <= 1'b1;
               rx_byte  <= shift_rx;
            end else begin
               shift_tx <= shift_tx << 1;
               mosi     <= shift_tx[DATA_W-2];
            end
         end
         if ((state == GAP) && tick) begin
            mosi <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: cycle table for one CLK_DIV=2 frame plus
// hand sequences for hold, busy-start, mid-frame reset, streaming and CLK_DIV=255.
module tb_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       miso;
   logic       ready, busy, rx_valid, sclk, ss, mosi;
   logic [7:0] rx_byte;

   logic       start2 = 1'b0;
   logic [7:0] tx2 = 8'h00;
   logic       ready2, busy2, rv2, sclk2, ss2, mosi2;
   logic [7:0] rxb2;

   spi_master #(.CLK_DIV(2), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .tx_byte(tx_byte),
      .miso(miso), .ready(ready), .busy(busy), .rx_valid(rx_valid),
      .rx_byte(rx_byte), .sclk(sclk), .ss(ss), .mosi(mosi)
   );

   spi_master #(.CLK_DIV(255), .DATA_W(8)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .hold(1'b0), .tx_byte(tx2),
      .miso(mosi2), .ready(ready2), .busy(busy2), .rx_valid(rv2),
      .rx_byte(rxb2), .sclk(sclk2), .ss(ss2), .mosi(mosi2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Mode-0 slave: MSB presented while ss is high, next bit after each sclk fall.
   logic [7:0] slave_q [0:3];
   logic [7:0] sl_sh = 8'h00;
   logic [2:0] sl_cnt = 3'd0;
   logic [1:0] sl_idx = 2'd0;
   logic       sl_sclk_q = 1'b0;
   assign miso = sl_sh[7];

   always @(posedge clk) begin
      sl_sclk_q <= sclk;
      if (ss) begin
         sl_idx <= 2'd0;
         sl_cnt <= 3'd0;
         sl_sh  <= slave_q[0];
      end else if (sl_sclk_q && !sclk) begin
         if (sl_cnt == 3'd7) begin
            sl_cnt <= 3'd0;
            sl_sh  <= slave_q[sl_idx + 2'd1];
            sl_idx <= sl_idx + 2'd1;
         end else begin
            sl_cnt <= sl_cnt + 3'd1;
            sl_sh  <= sl_sh << 1;
         end
      end
   end

   logic        mon_clr = 1'b0;
   int          m_rise = 0, m_rv = 0, m_ssrise = 0, m_ssfall = 0, m_sshi = 0, m_gapmin = 999;
   logic [15:0] m_cap = '0;
   logic        m_psclk = 1'b0, m_pss = 1'b1;

   always @(negedge clk) begin
      if (mon_clr) begin
         m_rise = 0; m_rv = 0; m_ssrise = 0; m_ssfall = 0; m_sshi = 0; m_gapmin = 999;
         m_cap = '0; m_psclk = sclk; m_pss = ss;
      end else begin
         if (sclk && !m_psclk) begin
            m_rise++;
            m_cap = {m_cap[14:0], mosi};
         end
         if (rx_valid) m_rv++;
         if (ss && !m_pss) m_ssrise++;
         if (!ss && m_pss) begin
            if (m_ssfall > 0 && m_sshi < m_gapmin) m_gapmin = m_sshi;
            m_ssfall++;
         end
         m_sshi  = ss ? m_sshi + 1 : 0;
         m_psclk = sclk;
         m_pss   = ss;
      end
   end

   int   hi2 = 0, lo2 = 0, last_hi2 = 0, last_lo2 = 0, r2 = 0;
   logic p2 = 1'b0;

   always @(negedge clk) begin
      if (sclk2) begin
         if (!p2) begin
            last_lo2 = lo2;
            r2++;
         end
         hi2++;
         lo2 = 0;
      end else begin
         if (p2) begin
            last_hi2 = hi2;
            hi2 = 0;
         end
         lo2 = ss2 ? 0 : lo2 + 1;
      end
      p2 = sclk2;
   end

   task automatic clr_mon();
      @(posedge clk); mon_clr = 1'b1;
      @(posedge clk); mon_clr = 1'b0;
   endtask

   // Returns at the negedge of cycle 1 (start accepted on the edge ending cycle 0).
   task automatic do_start(input logic [7:0] b);
      @(negedge clk); tx_byte = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_rv(input int n, input int budget, input string name);
      logic ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (m_rv >= n) begin ok = 1'b1; break; end
      end
      chk(name, ok, 1'b1);
   endtask

   task automatic wait_ready(input int budget, input string name);
      logic ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ready) begin ok = 1'b1; break; end
      end
      chk(name, ok, 1'b1);
   endtask

   typedef struct {
      int   cyc;
      logic sclk, ss, mosi, rv, rdy;
   } vec_t;

   vec_t tbl [21];
   logic tr_sclk [0:40], tr_ss [0:40], tr_mosi [0:40], tr_rv [0:40], tr_rdy [0:40];
   logic [7:0] tr_rxb [0:40];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[15] = '{32, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[16] = '{33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[17] = '{34, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[18] = '{35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[19] = '{36, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[20] = '{37, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) slave_q[i] = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", ready, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_ss", ss, 1'b1);
      chk("reset_sclk", sclk, 1'b0);
      chk("reset_mosi", mosi, 1'b0);
      chk("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_rx_byte", rx_byte, 8'h00);
      chk("reset2_busy", busy2, 1'b0);
      chk("reset2_ss", ss2, 1'b1);

      // Frame 0xA5 out, slave returns 0x3C; cycle-by-cycle table.
      slave_q[0] = 8'h3C;
      clr_mon();
      @(negedge clk); tx_byte = 8'hA5; start = 1'b1;
      tr_sclk[0] = sclk; tr_ss[0] = ss; tr_mosi[0] = mosi; tr_rv[0] = rx_valid;
      tr_rdy[0] = ready; tr_rxb[0] = rx_byte;
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         tr_sclk[c] = sclk; tr_ss[c] = ss; tr_mosi[c] = mosi; tr_rv[c] = rx_valid;
         tr_rdy[c] = ready; tr_rxb[c] = rx_byte;
      end
      for (int i = 0; i < 21; i++) begin
         chk($sformatf("c%0d_sclk", tbl[i].cyc), tr_sclk[tbl[i].cyc], tbl[i].sclk);
         chk($sformatf("c%0d_ss", tbl[i].cyc), tr_ss[tbl[i].cyc], tbl[i].ss);
         chk($sformatf("c%0d_mosi", tbl[i].cyc), tr_mosi[tbl[i].cyc], tbl[i].mosi);
         chk($sformatf("c%0d_rx_valid", tbl[i].cyc), tr_rv[tbl[i].cyc], tbl[i].rv);
         chk($sformatf("c%0d_ready", tbl[i].cyc), tr_rdy[tbl[i].cyc], tbl[i].rdy);
      end
      chk("f1_rx_byte", tr_rxb[33], 8'h3C);
      chk("f1_mosi_at_rises", m_cap[7:0], 8'hA5);
      chk("f1_rises", m_rise, 8);
      chk("f1_rx_pulses", m_rv, 1);

      // Two frames joined by hold.
      slave_q[0] = 8'h96; slave_q[1] = 8'h69;
      clr_mon();
      hold = 1'b1;
      do_start(8'h01);
      wait_rv(1, 100, "hold_f1_timeout");
      chk("hold_f1_rx_byte", rx_byte, 8'h96);
      wait_ready(20, "hold_ready_timeout");
      chk("hold_ss_low", ss, 1'b0);
      repeat (20) @(negedge clk);
      chk("hold_persist_ss", ss, 1'b0);
      chk("hold_persist_ready", ready, 1'b1);
      hold = 1'b0;
      do_start(8'h80);
      wait_rv(2, 100, "hold_f2_timeout");
      chk("hold_f2_rx_byte", rx_byte, 8'h69);
      chk("hold_no_ss_rise", m_ssrise, 0);
      wait_ready(50, "hold_idle_timeout");
      chk("hold_rises", m_rise, 16);
      chk("hold_ss_rises", m_ssrise, 1);
      chk("hold_ss_falls", m_ssfall, 1);
      chk("hold_rx_pulses", m_rv, 2);
      chk("hold_mosi_at_rises", m_cap, 16'h0180);

      // start pulses at cycles 5 and 20 of a busy frame.
      slave_q[0] = 8'hC5;
      clr_mon();
      do_start(8'hC3);
      repeat (4) @(negedge clk);
      tx_byte = 8'hFF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (14) @(negedge clk);
      tx_byte = 8'h00; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_rv(1, 100, "busy_timeout");
      chk("busy_rx_byte", rx_byte, 8'hC5);
      wait_ready(50, "busy_ready_timeout");
      repeat (60) @(negedge clk);
      chk("busy_rx_pulses", m_rv, 1);
      chk("busy_ss_falls", m_ssfall, 1);
      chk("busy_rises", m_rise, 8);
      chk("busy_mosi_at_rises", m_cap[7:0], 8'hC3);
      chk("busy_rx_byte_held", rx_byte, 8'hC5);

      // Reset at cycle 12 of a frame.
      slave_q[0] = 8'hAA;
      clr_mon();
      do_start(8'h3C);
      repeat (11) @(negedge clk);
      chk("pre_rst_sclk", sclk, 1'b1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_ss", ss, 1'b1);
      chk("rst_ready", ready, 1'b1);
      chk("rst_mosi", mosi, 1'b0);
      repeat (40) @(negedge clk);
      chk("rst_no_rx_valid", m_rv, 0);
      chk("rst_rx_byte", rx_byte, 8'h00);
      slave_q[0] = 8'h00;
      do_start(8'hFF);
      wait_rv(1, 100, "rst_ff_timeout");
      chk("rst_ff_rx_byte", rx_byte, 8'h00);
      wait_ready(50, "rst_ff_ready_timeout");
      chk("rst_ff_mosi", m_cap[7:0], 8'hFF);
      slave_q[0] = 8'hFF;
      do_start(8'h00);
      wait_rv(2, 100, "rst_00_timeout");
      chk("rst_00_rx_byte", rx_byte, 8'hFF);
      wait_ready(50, "rst_00_ready_timeout");
      chk("rst_00_mosi", m_cap[7:0], 8'h00);

      // start held high: frames accepted at cycles 0, 37, 74.
      clr_mon();
      @(negedge clk); tx_byte = 8'h81; start = 1'b1;
      repeat (100) @(negedge clk);
      start = 1'b0;
      repeat (60) @(negedge clk);
      chk("stream_frames", m_rv, 3);
      chk("stream_ss_falls", m_ssfall, 3);
      chk("stream_min_gap", m_gapmin, 3);

      // CLK_DIV=255 loopback.
      begin
         logic ok2 = 1'b0;
         @(negedge clk); tx2 = 8'h5A; start2 = 1'b1;
         @(negedge clk); start2 = 1'b0;
         for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (rv2) begin ok2 = 1'b1; break; end
         end
         chk("div255_rx_timeout", ok2, 1'b1);
         chk("div255_rx_byte", rxb2, 8'h5A);
         ok2 = 1'b0;
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ready2) begin ok2 = 1'b1; break; end
         end
         chk("div255_ready_timeout", ok2, 1'b1);
         chk("div255_hi_phase", last_hi2, 255);
         chk("div255_lo_phase", last_lo2, 255);
         chk("div255_rises", r2, 8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI bus master: FPGA drives sclk, ss and mosi, and samples miso. It is the initiator end of the same SPI link our slave-side path receives on.
- Used for FPGA-to-FPGA loopback, and to drive external SPI peripherals from fabric logic.
- Byte-oriented start/ready handshake on the fabric side.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, ss active-low.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 2..255.
- DATA_W, 8, bits per transfer frame.

Ports:
- clk  input  1  system clock (50 MHz CLOCK_50 domain).
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a transfer; accepted only when ready=1.
- hold  input  1  keep ss asserted after the current frame; sampled on the frame-end cycle.
- tx_byte  input  DATA_W  frame to send; captured on the accepted start cycle.
- miso  input  1  serial data from slave; already synchronized externally.
- ready  output  1  block can accept start.
- busy  output  1  frame in progress (equals ~ready).
- rx_valid  output  1  one-cycle pulse; rx_byte is valid in that cycle.
- rx_byte  output  DATA_W  last received frame; holds its value until the next rx_valid.
- sclk  output  1  serial clock; idles low.
- ss  output  1  slave select, active-low.
- mosi  output  1  serial data to slave.

Behaviour:
- Reset (rst=1 at a posedge clk) applies next cycle regardless of state:
  - state=IDLE, sclk=0, ss=1, mosi=0, ready=1, busy=0, rx_valid=0, rx_byte=0, counters cleared.
  - Reset mid-frame aborts the frame immediately; no rx_valid is produced.
- States: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, TEARDOWN, GAP.
- Half-period timer div_cnt: loads CLK_DIV-1 on each state or phase entry and advances the phase at 0. A bit counter tracks bits remaining.
- IDLE: ready=1. On start:
  - shift_tx loads tx_byte; ss=0 and mosi=tx_byte[DATA_W-1] take effect the next cycle.
  - Go to SETUP.
- SETUP: ss low and sclk low for CLK_DIV cycles, then go to SCK_HI.
- SCK_HI (entered with sclk rising): sample miso into the LSB of shift_rx on the rising-edge cycle. Stay CLK_DIV cycles, then go to SCK_LO.
- SCK_LO (entered with sclk falling):
  - If bits remain, mosi advances to the next bit on the falling-edge cycle; after CLK_DIV cycles go to SCK_HI.
  - After the DATA_W-th falling edge this is the frame end:
    - rx_valid=1 for exactly that cycle; rx_byte = the assembled byte.
    - If hold=1, go to HOLD; else go to TEARDOWN.
- Timing, with start accepted at cycle 0:
  - ss falls at cycle 1.
  - First sclk rise at cycle 1+CLK_DIV.
  - Rise k (k=0..DATA_W-1) at cycle 1+CLK_DIV+2k·CLK_DIV.
  - rx_valid at cycle 1+2·DATA_W·CLK_DIV.
- HOLD: ss stays 0, sclk 0, ready=1.
  - On start: load tx_byte, drive mosi=MSB, go to SETUP; ss is not toggled between frames.
  - There is no timeout; HOLD persists until start or rst.
- TEARDOWN: ss stays 0 for CLK_DIV cycles, then ss=1 and go to GAP.
- GAP: ss high for CLK_DIV cycles minimum deselect time, then go to IDLE.
- start while ready=0 is ignored entirely, with no queueing; tx_byte changes while busy have no effect.
- start and hold both asserted in HOLD: start is accepted; hold is re-sampled at the next frame end.
- mosi holds its last driven bit when not shifting; it returns to 0 in IDLE.
- ready is combinational from state: IDLE or HOLD.

Decomposition:
- spi_pkg holds:
  - spi_state_t enum (the seven states).
  - SPI_MODE0 constants (CPOL=0, CPHA=0).
  - A function clog2 for sizing the bit counter.
- One sub-module, spi_clk_div: a loadable half-period down-counter with a tick output when it reaches zero. The FSM, shift registers and handshake stay in spi_master.

Test Plan:
- CLK_DIV=2, tx_byte=0xA5, miso driven by a mode-0 slave model returning 0x3C → ss low at cycle 1; sclk rises at cycles 3,7,…,31; mosi reads 1,0,1,0,0,1,0,1 at the rises; rx_valid at cycle 33 with rx_byte=0x3C; ss high at cycle 35; ready at cycle 37.
- Two frames with hold=1 on the first: 0x01 then 0x80 → ss stays low continuously between frames; two rx_valid pulses; ss rises only after the second frame; exactly 16 sclk rising edges total.
- start pulsed while busy (cycles 5 and 20 of a frame) → ignored; the frame completes unchanged; no second frame follows.
- rst asserted at cycle 12 mid-frame → next cycle sclk=0, ss=1, ready=1; rx_valid never pulses; a new start afterwards produces a correct frame with 0xFF/0x00 patterns.
- CLK_DIV=255, DATA_W=8, loopback miso=mosi with tx_byte=0x5A → rx_byte=0x5A; sclk high and low phases each measure exactly 255 clk cycles.
- start held continuously high in IDLE with hold=0 → back-to-back frames, each separated by at least CLK_DIV cycles of ss high.
